// File: rtl/intr_arbiter_pkg.sv
// Shared types for the interrupt arbiter: FSM state encoding and interrupt-mode values.
// Pure declarations, no logic.
// No flow control.
package intr_arbiter_pkg;

  // Arbiter states. IDLE is the only state in which instruction boundaries are arbitrated.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUS_GRANT = 2'd1,
    ST_NMI_ACK   = 2'd2,
    ST_INT_ACK   = 2'd3
  } intr_state_t;

  localparam logic [1:0] IM0 = 2'd0;
  localparam logic [1:0] IM1 = 2'd1;
  localparam logic [1:0] IM2 = 2'd2;

  // The undefined IM encoding 3 behaves as mode 0.
  function automatic logic [1:0] im_decode(input logic [1:0] sel);
    return (sel == 2'd3) ? IM0 : sel;
  endfunction

endpackage

// File: rtl/intr_arbiter_nmi_latch.sv
// NMI edge detector and pending latch; remembers one NMI until its acknowledge starts.
// Latency: pend visible the cycle after the rising edge is sampled.
// No backpressure: extra edges while pending are absorbed.
module nmi_latch (
  input  logic clk,
  input  logic reset,
  input  logic nmi,
  input  logic clr,
  output logic nmi_pend
);

  logic nmi_d, nmi_q;
  logic nmi_pend_d, nmi_pend_q;

  // Edge detect against the previous level; clear on acknowledge entry wins over a new edge.
  always_comb begin
    nmi_d      = nmi;
    nmi_pend_d = nmi_pend_q;
    if (clr) begin
      nmi_pend_d = 1'b0;
    end else if (nmi && !nmi_q) begin
      nmi_pend_d = 1'b1;
    end
  end

  // nmi_q resets high so an NMI level held through reset is not mistaken for an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_q      <= 1'b1;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_q      <= nmi_d;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  assign nmi_pend = nmi_pend_q;

endmodule

// File: rtl/intr_arbiter.sv
// Instruction-boundary arbiter: bus grant, NMI ack, maskable ack; owns IFF1/IFF2, IM and EI shadow.
// Latency: decision on the instr_end clock, registered outputs valid the following cycle.
// No backpressure: ack states are held until ack_done, bus grant until busrq drops.
module intr_arbiter
  import intr_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       nmi,
  input  logic       intr,
  input  logic       busrq,
  input  logic       instr_end,
  input  logic       ack_done,
  input  logic       halt,
  input  logic       ctl_ei,
  input  logic       ctl_di,
  input  logic       ctl_retn,
  input  logic       ctl_im_we,
  input  logic [1:0] im_sel,
  output logic       iff1,
  output logic       iff2,
  output logic [1:0] im,
  output logic       nmi_take,
  output logic       int_take,
  output logic       busack,
  output logic       halt_exit
);

  intr_state_t state_d, state_q;
  logic        iff1_d, iff1_q;
  logic        iff2_d, iff2_q;
  logic [1:0]  im_d, im_q;
  logic        ei_shadow_d, ei_shadow_q;
  logic        busack_d, busack_q;
  logic        nmi_take_d, nmi_take_q;
  logic        int_take_d, int_take_q;
  logic        halt_exit_d, halt_exit_q;
  logic        nmi_entry;
  logic        int_entry;
  logic        nmi_pend;

  nmi_latch u_nmi_latch (
    .clk      (clk),
    .reset    (reset),
    .nmi      (nmi),
    .clr      (nmi_entry),
    .nmi_pend (nmi_pend)
  );

  // Next-state: fixed-priority arbitration at instruction end, exits from grant/ack states.
  always_comb begin
    state_d   = state_q;
    nmi_entry = 1'b0;
    int_entry = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_end) begin
          if (busrq) begin
            state_d = ST_BUS_GRANT;
          end else if (nmi_pend) begin
            state_d   = ST_NMI_ACK;
            nmi_entry = 1'b1;
          end else if (intr && iff1_q && !ei_shadow_q && !ctl_ei) begin
            state_d   = ST_INT_ACK;
            int_entry = 1'b1;
          end
        end
      end
      ST_BUS_GRANT: begin
        if (!busrq) state_d = ST_IDLE;
      end
      ST_NMI_ACK, ST_INT_ACK: begin
        if (ack_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs follow the next state; halt_exit only on an acknowledge entry while halted.
  always_comb begin
    busack_d    = (state_d == ST_BUS_GRANT);
    nmi_take_d  = (state_d == ST_NMI_ACK);
    int_take_d  = (state_d == ST_INT_ACK);
    halt_exit_d = halt && (nmi_entry || int_entry);
  end

  // IFF update with acknowledge entry overriding the decode strobes (DI > EI > RETN).
  always_comb begin
    iff1_d = iff1_q;
    iff2_d = iff2_q;
    if (nmi_entry) begin
      iff2_d = iff1_q;
      iff1_d = 1'b0;
    end else if (int_entry) begin
      iff1_d = 1'b0;
      iff2_d = 1'b0;
    end else if (ctl_di) begin
      iff1_d = 1'b0;
      iff2_d = 1'b0;
    end else if (ctl_ei) begin
      iff1_d = 1'b1;
      iff2_d = 1'b1;
    end else if (ctl_retn) begin
      iff1_d = iff2_q;
    end
  end

  // EI shadow covers the instruction that executed EI; it expires at that instruction's end.
  always_comb begin
    ei_shadow_d = ei_shadow_q;
    if (ctl_di) begin
      ei_shadow_d = 1'b0;
    end else if (instr_end && (state_q == ST_IDLE)) begin
      ei_shadow_d = 1'b0;
    end else if (ctl_ei) begin
      ei_shadow_d = 1'b1;
    end
  end

  // Interrupt mode register load.
  always_comb begin
    im_d = im_q;
    if (ctl_im_we) im_d = im_decode(im_sel);
  end

  // State and control registers; reset abandons any acknowledge in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      iff1_q      <= 1'b0;
      iff2_q      <= 1'b0;
      im_q        <= IM0;
      ei_shadow_q <= 1'b0;
      busack_q    <= 1'b0;
      nmi_take_q  <= 1'b0;
      int_take_q  <= 1'b0;
      halt_exit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iff1_q      <= iff1_d;
      iff2_q      <= iff2_d;
      im_q        <= im_d;
      ei_shadow_q <= ei_shadow_d;
      busack_q    <= busack_d;
      nmi_take_q  <= nmi_take_d;
      int_take_q  <= int_take_d;
      halt_exit_q <= halt_exit_d;
    end
  end

  assign iff1      = iff1_q;
  assign iff2      = iff2_q;
  assign im        = im_q;
  assign busack    = busack_q;
  assign nmi_take  = nmi_take_q;
  assign int_take  = int_take_q;
  assign halt_exit = halt_exit_q;

endmodule

// File: tb/tb_intr_arbiter.sv
// Directed bench for intr_arbiter with a scoreboard queue of expected output vectors.
// Each stimulus cycle pushes the outputs expected after the next clock edge.
// A monitor pops one entry per cycle, #1 after the rising edge, and compares.
module tb_intr_arbiter;

  logic       clk;
  logic       reset;
  logic       nmi, intr, busrq, instr_end, ack_done, halt;
  logic       ctl_ei, ctl_di, ctl_retn, ctl_im_we;
  logic [1:0] im_sel;
  logic       iff1, iff2, nmi_take, int_take, busack, halt_exit;
  logic [1:0] im;

  typedef struct {
    string      nm;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  intr_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .nmi       (nmi),
    .intr      (intr),
    .busrq     (busrq),
    .instr_end (instr_end),
    .ack_done  (ack_done),
    .halt      (halt),
    .ctl_ei    (ctl_ei),
    .ctl_di    (ctl_di),
    .ctl_retn  (ctl_retn),
    .ctl_im_we (ctl_im_we),
    .im_sel    (im_sel),
    .iff1      (iff1),
    .iff2      (iff2),
    .im        (im),
    .nmi_take  (nmi_take),
    .int_take  (int_take),
    .busack    (busack),
    .halt_exit (halt_exit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector layout: {busack, nmi_take, int_take, halt_exit, iff1, iff2, im[1:0]}
  function automatic logic [7:0] ev(input logic b, input logic n, input logic i, input logic h,
                                    input logic f1, input logic f2, input logic [1:0] m);
    return {b, n, i, h, f1, f2, m};
  endfunction

  // Push the expectation for the inputs currently driven, then advance one cycle and drop strobes.
  task automatic tick(input string nm, input logic [7:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    q.push_back(e);
    @(negedge clk);
    reset     = 1'b0;
    instr_end = 1'b0;
    ack_done  = 1'b0;
    ctl_ei    = 1'b0;
    ctl_di    = 1'b0;
    ctl_retn  = 1'b0;
    ctl_im_we = 1'b0;
  endtask

  // Monitor: one comparison per cycle whenever an expectation is queued.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {busack, nmi_take, int_take, halt_exit, iff1, iff2, im};
        n_checks++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: got b/n/i/h/f1/f2/im=%b required %b", e.nm, act, e.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int drain;
    reset = 1'b1; nmi = 1'b1; intr = 1'b0; busrq = 1'b0; instr_end = 1'b0; ack_done = 1'b0;
    halt = 1'b0; ctl_ei = 1'b0; ctl_di = 1'b0; ctl_retn = 1'b0; ctl_im_we = 1'b0; im_sel = 2'd0;
    @(negedge clk);

    // Reset with NMI held, IM writes
    reset = 1'b1;                          tick("reset",        ev(0,0,0,0,0,0,0));
    instr_end = 1'b1;                      tick("nmi_held_1",   ev(0,0,0,0,0,0,0));
    instr_end = 1'b1;                      tick("nmi_held_2",   ev(0,0,0,0,0,0,0));
    nmi = 1'b0;
    ctl_im_we = 1'b1; im_sel = 2'd2;       tick("im2",          ev(0,0,0,0,0,0,2));
    ctl_im_we = 1'b1; im_sel = 2'd3;       tick("im3_to_0",     ev(0,0,0,0,0,0,0));
    ctl_im_we = 1'b1; im_sel = 2'd1;       tick("im1",          ev(0,0,0,0,0,0,1));

    // EI shadow with INT held
    intr = 1'b1; ctl_ei = 1'b1;            tick("ei",           ev(0,0,0,0,1,1,1));
    instr_end = 1'b1;                      tick("ei_shadow",    ev(0,0,0,0,1,1,1));
    instr_end = 1'b1;                      tick("int_take",     ev(0,0,1,0,0,0,1));
                                           tick("int_hold",     ev(0,0,1,0,0,0,1));
    ack_done = 1'b1; intr = 1'b0;          tick("int_done",     ev(0,0,0,0,0,0,1));

    // NMI with an absorbed second edge, then RETN
    ctl_ei = 1'b1;                         tick("ei2",          ev(0,0,0,0,1,1,1));
    nmi = 1'b1;                            tick("nmi_edge1",    ev(0,0,0,0,1,1,1));
    nmi = 1'b0;                            tick("nmi_low",      ev(0,0,0,0,1,1,1));
    nmi = 1'b1;                            tick("nmi_edge2",    ev(0,0,0,0,1,1,1));
    nmi = 1'b0; instr_end = 1'b1;          tick("nmi_take",     ev(0,1,0,0,0,1,1));
    instr_end = 1'b1;                      tick("nmi_ie_ign",   ev(0,1,0,0,0,1,1));
    ack_done = 1'b1;                       tick("nmi_done",     ev(0,0,0,0,0,1,1));
    instr_end = 1'b1;                      tick("nmi_no_retake",ev(0,0,0,0,0,1,1));
    ctl_retn = 1'b1;                       tick("retn",         ev(0,0,0,0,1,1,1));

    // Priority: busrq over pending NMI over enabled INT
    nmi = 1'b1; intr = 1'b1;               tick("pri_pend",     ev(0,0,0,0,1,1,1));
    nmi = 1'b0; busrq = 1'b1; instr_end = 1'b1;
                                           tick("pri_busack",   ev(1,0,0,0,1,1,1));
    instr_end = 1'b1;                      tick("bus_ie_ign",   ev(1,0,0,0,1,1,1));
    busrq = 1'b0;                          tick("bus_release",  ev(0,0,0,0,1,1,1));
    instr_end = 1'b1;                      tick("pri_nmi",      ev(0,1,0,0,0,1,1));
    ack_done = 1'b1; ctl_retn = 1'b1;      tick("pri_nmi_done", ev(0,0,0,0,1,1,1));
    instr_end = 1'b1;                      tick("pri_int",      ev(0,0,1,0,0,0,1));
    ack_done = 1'b1; intr = 1'b0;          tick("pri_int_done", ev(0,0,0,0,0,0,1));

    // HALT exit
    ctl_ei = 1'b1;                         tick("halt_ei",      ev(0,0,0,0,1,1,1));
    halt = 1'b1; instr_end = 1'b1;         tick("halt_nop",     ev(0,0,0,0,1,1,1));
    intr = 1'b1; instr_end = 1'b1;         tick("halt_exit",    ev(0,0,1,1,0,0,1));
                                           tick("halt_exit_1cy",ev(0,0,1,0,0,0,1));
    ack_done = 1'b1;                       tick("halt_done",    ev(0,0,0,0,0,0,1));
    instr_end = 1'b1;                      tick("halt_iff_off", ev(0,0,0,0,0,0,1));
    busrq = 1'b1; instr_end = 1'b1;        tick("halt_bus",     ev(1,0,0,0,0,0,1));
    busrq = 1'b0;                          tick("halt_bus_rel", ev(0,0,0,0,0,0,1));
    halt = 1'b0; intr = 1'b0;

    // Reset during INT_ACK
    ctl_ei = 1'b1;                         tick("mr_ei",        ev(0,0,0,0,1,1,1));
    intr = 1'b1; instr_end = 1'b1;         tick("mr_shadow",    ev(0,0,0,0,1,1,1));
    instr_end = 1'b1;                      tick("mr_int",       ev(0,0,1,0,0,0,1));
    ctl_ei = 1'b1;                         tick("mr_ei_in_ack", ev(0,0,1,0,1,1,1));
    reset = 1'b1;                          tick("mr_reset",     ev(0,0,0,0,0,0,0));
    intr = 1'b0; ack_done = 1'b1;          tick("mr_stale_ack", ev(0,0,0,0,0,0,0));
    instr_end = 1'b1;                      tick("mr_idle",      ev(0,0,0,0,0,0,0));

    // DI and DI-over-EI precedence
    ctl_ei = 1'b1;                         tick("di_pre_ei",    ev(0,0,0,0,1,1,0));
    ctl_di = 1'b1;                         tick("di",           ev(0,0,0,0,0,0,0));
    ctl_ei = 1'b1; ctl_di = 1'b1;          tick("di_over_ei",   ev(0,0,0,0,0,0,0));

    // NMI edge coincident with instr_end is only taken at the following boundary
    nmi = 1'b1; instr_end = 1'b1;          tick("nmi_same_cy",  ev(0,0,0,0,0,0,0));
    nmi = 1'b0; instr_end = 1'b1;          tick("nmi_next_ie",  ev(0,1,0,0,0,0,0));
    ack_done = 1'b1;                       tick("nmi_next_done",ev(0,0,0,0,0,0,0));

    drain = 0;
    while (q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
